// File: rtl/rom_fetch_unit_pkg.sv
// Shared types and constants for the program-ROM fetch unit.
package rom_fetch_unit_pkg;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;

    localparam logic [ADDR_W-1:0] RESET_VECTOR = 8'h00;

    // One prefetched byte together with the ROM address it came from.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
    } fetch_entry_t;

    // RESET_FILL: waiting for the first byte after reset/redirect.
    // STREAM:     at least one byte captured since the last restart.
    typedef enum logic [0:0] {
        RESET_FILL = 1'b0,
        STREAM     = 1'b1
    } fetch_state_t;

    // Next sequential fetch address; wraps modulo 2**ADDR_W.
    function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/rom_fetch_unit_if.sv
// Bus bundle between the fetch unit, the program ROM and the CPU decoder.
// The master modport is the fetch unit; the slave modport is its environment.
interface rom_fetch_unit_if;

    logic [rom_fetch_unit_pkg::ADDR_W-1:0] rom_addr;
    logic [rom_fetch_unit_pkg::DATA_W-1:0] rom_data;
    logic                                  redirect;
    logic [rom_fetch_unit_pkg::ADDR_W-1:0] redirect_addr;
    logic                                  instr_valid;
    logic                                  instr_ready;
    logic [rom_fetch_unit_pkg::DATA_W-1:0] instr_data;
    logic [rom_fetch_unit_pkg::ADDR_W-1:0] instr_addr;

    modport master (
        output rom_addr,
        input  rom_data,
        input  redirect,
        input  redirect_addr,
        output instr_valid,
        input  instr_ready,
        output instr_data,
        output instr_addr
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        output redirect,
        output redirect_addr,
        input  instr_valid,
        output instr_ready,
        input  instr_data,
        input  instr_addr
    );

endinterface

// File: rtl/rom_fetch_unit_fifo.sv
// Prefetch buffer: synchronous FIFO of fetch entries with flush.
// Flush wins over push and pop; the head is read straight from storage.
module fetch_fifo
    import rom_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  fetch_entry_t                 push_entry,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic empty_s;
    logic full_s;
    logic do_push_s;
    logic do_pop_s;

    // Occupancy flags and qualified push/pop (never pop empty, never push full).
    always_comb begin
        empty_s   = (count_r == CNT_W'(0));
        full_s    = (count_r == CNT_W'(DEPTH));
        do_pop_s  = pop & ~empty_s;
        do_push_s = push & (~full_s | do_pop_s);
    end

    // Storage, pointers and count; flush empties the buffer in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{data: 8'h00, addr: 8'h00};
            end
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else if (flush) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_entry;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign empty = empty_s;

endmodule

// File: rtl/rom_fetch_unit.sv
// Program-ROM fetch unit: sequential address generation, capture of the
// ROM's one-cycle read data, prefetch buffering and redirect handling.
// An epoch bit tags each in-flight request so data for a request issued
// before a redirect is never captured.
module rom_fetch_unit
    import rom_fetch_unit_pkg::*;
#(
    parameter int FIFO_DEPTH_P = FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    rom_fetch_unit_if.master bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH_P) + 1;

    logic [ADDR_W-1:0] pc_r;
    logic              infl_valid_r;
    logic [ADDR_W-1:0] infl_addr_r;
    logic              infl_epoch_r;
    logic              epoch_r;
    fetch_state_t      state_r;
    fetch_state_t      state_next_s;

    logic              pop_s;
    logic              push_s;
    logic              issue_s;
    logic [CNT_W:0]    occupancy_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic              fifo_empty_s;
    fetch_entry_t      head_s;
    fetch_entry_t      push_entry_s;

    // Handshake, capture and credit decisions; redirect suppresses all three.
    always_comb begin
        pop_s        = ~fifo_empty_s & bus.instr_ready & ~bus.redirect;
        push_s       = ~bus.redirect & infl_valid_r & (infl_epoch_r == epoch_r);
        occupancy_s  = {1'b0, fifo_count_s}
                     + {{CNT_W{1'b0}}, infl_valid_r}
                     - {{CNT_W{1'b0}}, pop_s};
        issue_s      = ~bus.redirect & (occupancy_s < (CNT_W+1)'(FIFO_DEPTH_P));
        push_entry_s = '{data: bus.rom_data, addr: infl_addr_r};
    end

    fetch_fifo #(
        .DEPTH      (FIFO_DEPTH_P)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .flush      (bus.redirect),
        .head       (head_s),
        .count      (fifo_count_s),
        .empty      (fifo_empty_s)
    );

    // PC, in-flight request tracking and epoch; redirect restarts fetching.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r         <= RESET_VECTOR;
            infl_valid_r <= 1'b0;
            infl_addr_r  <= RESET_VECTOR;
            infl_epoch_r <= 1'b0;
            epoch_r      <= 1'b0;
        end else if (bus.redirect) begin
            pc_r         <= bus.redirect_addr;
            infl_valid_r <= 1'b0;
            epoch_r      <= ~epoch_r;
        end else begin
            infl_valid_r <= issue_s;
            if (issue_s) begin
                infl_addr_r  <= pc_r;
                infl_epoch_r <= epoch_r;
                pc_r         <= pc_next(pc_r);
            end else begin
                pc_r         <= pc_r;
            end
        end
    end

    // Fill/stream status register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RESET_FILL;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Fill/stream next state: first capture enters STREAM, redirect returns to RESET_FILL.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            RESET_FILL: begin
                if (bus.redirect) begin
                    state_next_s = RESET_FILL;
                end else if (push_s) begin
                    state_next_s = STREAM;
                end else begin
                    state_next_s = RESET_FILL;
                end
            end
            STREAM: begin
                if (bus.redirect) begin
                    state_next_s = RESET_FILL;
                end else begin
                    state_next_s = STREAM;
                end
            end
            default: state_next_s = RESET_FILL;
        endcase
    end

    assign bus.rom_addr    = pc_r;
    assign bus.instr_valid = ~fifo_empty_s;
    assign bus.instr_data  = head_s.data;
    assign bus.instr_addr  = head_s.addr;

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Self-checking bench for rom_fetch_unit. A transaction-level model keeps
// the expected buffer contents as a queue of addresses plus one pending ROM
// request, and every cycle the visible outputs are compared against it.
module tb_rom_fetch_unit;

    logic clk = 1'b0;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    rom_fetch_unit_if bus_if ();

    rom_fetch_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    // Program ROM: one-cycle registered read, ROM[a] = a ^ 8'h5A.
    always @(posedge clk) begin
        bus_if.rom_data <= bus_if.rom_addr ^ 8'h5A;
    end

    // Reference model state.
    logic [7:0] exp_q [$];
    logic [7:0] m_pc;
    bit         m_pend;
    logic [7:0] m_pend_addr;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pc   = 8'h00;
        m_pend = 1'b0;
    endtask

    // One clock edge of the fetch rules: redirect restarts; otherwise a pending
    // request lands in the buffer and a new one is issued while room remains.
    task automatic model_edge(input bit redir, input logic [7:0] ra, input bit rdy);
        bit pop;
        bit issue;
        pop = (exp_q.size() != 0) && rdy && !redir;
        if (redir) begin
            exp_q.delete();
            m_pc   = ra;
            m_pend = 1'b0;
        end else begin
            issue = (exp_q.size() + int'(m_pend) - int'(pop)) < 4;
            if (pop) void'(exp_q.pop_front());
            if (m_pend) exp_q.push_back(m_pend_addr);
            if (issue) begin
                m_pend_addr = m_pc;
                m_pc        = m_pc + 8'h01;
            end
            m_pend = issue;
        end
    endtask

    task automatic check_outputs();
        check_eq("instr_valid", 32'(bus_if.instr_valid), 32'(exp_q.size() != 0));
        check_eq("rom_addr", 32'(bus_if.rom_addr), 32'(m_pc));
        if (exp_q.size() != 0) begin
            check_eq("instr_addr", 32'(bus_if.instr_addr), 32'(exp_q[0]));
            check_eq("instr_data", 32'(bus_if.instr_data), 32'(exp_q[0] ^ 8'h5A));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, 32'(bus_if.instr_valid), 32'h0);
        check_eq({tag, "_rom_addr"}, 32'(bus_if.rom_addr), 32'h0);
        check_eq({tag, "_data"}, 32'(bus_if.instr_data), 32'h0);
        check_eq({tag, "_addr"}, 32'(bus_if.instr_addr), 32'h0);
    endtask

    // Apply inputs for one cycle, advance the model at the edge, check just after.
    task automatic step(input bit redir, input logic [7:0] ra, input bit rdy);
        bus_if.redirect      = redir;
        bus_if.redirect_addr = ra;
        bus_if.instr_ready   = rdy;
        @(posedge clk);
        model_edge(redir, ra, rdy);
        #1;
        check_outputs();
    endtask

    initial begin
        bit rdy;
        bit redir;
        int hold;

        rst_n                = 1'b0;
        bus_if.redirect      = 1'b0;
        bus_if.redirect_addr = 8'h00;
        bus_if.instr_ready   = 1'b0;
        model_reset();

        // Reset state, then streaming from the reset vector.
        #22;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) step(1'b0, 8'h00, 1'b1);

        // Consumer stall: buffer fills, fetch address freezes, then drains.
        repeat (10) step(1'b0, 8'h00, 1'b0);
        repeat (12) step(1'b0, 8'h00, 1'b1);

        // Redirect while three entries are buffered and one request is in flight.
        step(1'b1, 8'h00, 1'b0);
        repeat (4) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h80, 1'b0);
        repeat (6) step(1'b0, 8'h00, 1'b1);

        // Address wrap past 8'hFF.
        step(1'b1, 8'hFE, 1'b1);
        repeat (6) step(1'b0, 8'h00, 1'b1);

        // Back-to-back redirects with an accepted-looking handshake on the edge.
        step(1'b1, 8'h10, 1'b1);
        step(1'b1, 8'h20, 1'b1);
        repeat (6) step(1'b0, 8'h00, 1'b1);

        // Asynchronous reset mid-stream takes effect before the next edge.
        repeat (3) step(1'b0, 8'h00, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        #2;
        rst_n = 1'b1;
        repeat (8) step(1'b0, 8'h00, 1'b1);

        // Randomized traffic: ready bursts, stalls and occasional redirects.
        hold = 0;
        rdy  = 1'b1;
        repeat (1500) begin
            if (hold == 0) begin
                rdy  = ($urandom_range(0, 3) != 0);
                hold = $urandom_range(1, 8);
            end
            hold--;
            redir = ($urandom_range(0, 15) == 0);
            step(redir, 8'($urandom), rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
